// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter sharing one matched-delay chain between N_REQ requesters.
// Each grant runs a full return-to-zero pulse through the chain, with timeout recovery.
module delay_line_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       del_in,
  input  logic                       del_out,
  output logic                       timeout_err,
  input  logic                       err_clr
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_ACKH, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 del_s;
  logic [IdW-1:0]       gid_q, gid_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [IdW-1:0]       pick;
  logic                 found;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 del_in_q, del_in_d;
  logic                 err_q, err_d;
  logic                 err_set;
  logic [CntW-1:0]      cnt_q, cnt_d;

  // del_out is asynchronous to clk; only the last stage is used by the FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], del_out};
    end
  end

  assign del_s = sync_q[SYNC_STAGES-1];

  // First set request at or above ptr, otherwise the lowest set request (wrap)
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found && req[j] && (j >= 32'(ptr_q))) begin
        found = 1'b1;
        pick  = IdW'(j);
      end
    end
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IdW'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    del_in_d = del_in_q;
    cnt_d    = cnt_q;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gid_d    = pick;
          ptr_d    = (pick == IdW'(N_REQ - 1)) ? '0 : pick + IdW'(1);
          del_in_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_FIRE;
        end
      end
      S_FIRE: begin
        cnt_d = cnt_q + CntW'(1);
        if (del_s || (cnt_q == CntLast)) begin
          err_set = !del_s;
          ack_d   = N_REQ'(1) << gid_q;
          state_d = S_ACKH;
        end
      end
      S_ACKH: begin
        if (!req[gid_q]) begin
          del_in_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CntW'(1);
        if (!del_s || (cnt_q == CntLast)) begin
          err_set = del_s;
          ack_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout in the same cycle as err_clr keeps the flag set
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      gid_q    <= '0;
      ptr_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      del_in_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      del_in_q <= del_in_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ack         = ack_q;
  assign grant_id    = gid_q;
  assign busy        = busy_q;
  assign del_in      = del_in_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench for delay_line_arbiter: random and directed requester traffic checked
// against a transaction-level model of grant order, pulse latencies and the error flag.
module tb_delay_line_arbiter;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int PH_IDLE = 0, PH_FIRE = 1, PH_ACKH = 2, PH_DRAIN = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] ack;
  logic [1:0]   grant_id;
  logic         busy, del_in, del_out, timeout_err;
  logic         err_clr = 1'b0;

  logic chain = 1'b0;
  logic chain_v;
  bit   stuck0 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  int ph = PH_IDLE;
  int t0 = 0;
  int ptr_m = 0;
  int gid_m = 0;
  bit exp_err = 1'b0;
  int fire_lat = 3;
  int drain_lat = 3;
  int grants[$];

  // requester behaviour
  bit auto_en = 1'b0;
  bit stop = 1'b0;
  int cst[N];
  int ccnt[N];
  int gap_lo = 1, gap_hi = 1, hold_hi = 0;

  delay_line_arbiter #(.N_REQ(N), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .ack(ack), .grant_id(grant_id),
    .busy(busy), .del_in(del_in), .del_out(del_out),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // delay chain: 0.7 clock cycle transport delay
  always @(del_in) begin
    chain_v = del_in;
    #7;
    chain = chain_v;
  end
  assign del_out = stuck0 ? 1'b0 : chain;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, expected finish");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Called once per cycle with the outputs after the edge and the req the DUT saw
  task automatic model_step();
    bit err_set;
    int g;
    err_set = 1'b0;
    chk_eq("ack_onehot", ($countones(ack) <= 1) ? 1 : 0, 1);
    case (ph)
      PH_IDLE: begin
        if (req != '0) begin
          g = rr_pick(ptr_m, req);
          gid_m = g;
          ptr_m = (g + 1) % N;
          grants.push_back(g);
          chk_eq("del_in_rise", del_in, 1);
          chk_eq("busy_rise", busy, 1);
          chk_eq("ack_at_grant", ack, 0);
          t0 = cyc;
          ph = PH_FIRE;
        end else begin
          chk_eq("del_in_idle", del_in, 0);
          chk_eq("busy_idle", busy, 0);
          chk_eq("ack_idle", ack, 0);
        end
      end
      PH_FIRE: begin
        chk_eq("del_in_fire", del_in, 1);
        chk_eq("busy_fire", busy, 1);
        if (cyc - t0 == fire_lat) begin
          chk_eq("ack_rise", ack, 32'(1) << gid_m);
          if (fire_lat == TMO) err_set = 1'b1;
          t0 = cyc;
          ph = PH_ACKH;
        end else begin
          chk_eq("ack_fire", ack, 0);
        end
      end
      PH_ACKH: begin
        chk_eq("ack_ackh", ack, 32'(1) << gid_m);
        if (!req[gid_m]) begin
          chk_eq("del_in_fall", del_in, 0);
          t0 = cyc;
          ph = PH_DRAIN;
        end else begin
          chk_eq("del_in_ackh", del_in, 1);
        end
      end
      default: begin
        chk_eq("del_in_drain", del_in, 0);
        if (cyc - t0 == drain_lat) begin
          chk_eq("ack_fall", ack, 0);
          chk_eq("busy_fall", busy, 0);
          ph = PH_IDLE;
        end else begin
          chk_eq("ack_drain", ack, 32'(1) << gid_m);
          chk_eq("busy_drain", busy, 1);
        end
      end
    endcase
    chk_eq("grant_id", grant_id, gid_m);
    if (err_set) exp_err = 1'b1;
    else if (err_clr) exp_err = 1'b0;
    chk_eq("timeout_err", timeout_err, exp_err);
  endtask

  task automatic client_step();
    for (int i = 0; i < N; i++) begin
      if (cst[i] == 0 && !ack[i]) cst[i] = 1;
      if (cst[i] == 1 && ack[i]) begin
        cst[i] = 2;
        ccnt[i] = int'($urandom_range(hold_hi, 0));
      end
      if (cst[i] == 2) begin
        if (ccnt[i] == 0) begin
          cst[i] = 3;
          ccnt[i] = int'($urandom_range(gap_hi, gap_lo));
          req[i] = 1'b0;
        end else begin
          ccnt[i]--;
        end
      end else if (cst[i] == 3) begin
        ccnt[i]--;
        if (ccnt[i] <= 0) begin
          if (stop) begin
            cst[i] = 4;
          end else begin
            cst[i] = 0;
            req[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rstn) model_step();
    if (auto_en) client_step();
  endtask

  task automatic model_reset();
    ph = PH_IDLE;
    ptr_m = 0;
    gid_m = 0;
    exp_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic start_clients(input logic [N-1:0] mask);
    stop = 1'b0;
    for (int i = 0; i < N; i++) begin
      cst[i] = mask[i] ? 0 : 4;
      req[i] = mask[i];
    end
    auto_en = 1'b1;
  endtask

  function automatic bit clients_done();
    for (int i = 0; i < N; i++) begin
      if (cst[i] != 4) return 1'b0;
    end
    return (ph == PH_IDLE) && !busy;
  endfunction

  task automatic drain_clients(input string tag);
    stop = 1'b1;
    for (int k = 0; k < 400 && !clients_done(); k++) tick();
    chk_eq(tag, clients_done(), 1);
    auto_en = 1'b0;
  endtask

  initial begin
    int cnt[N];
    for (int i = 0; i < N; i++) cst[i] = 4;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_ack", ack, 0);
    chk_eq("rst_grant_id", grant_id, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_del_in", del_in, 0);
    chk_eq("rst_timeout_err", timeout_err, 0);
    rstn = 1'b1;
    tick();
    tick();

    // single pulse from requester 0
    req = 4'b0001;
    for (int k = 0; k < 20 && !ack[0]; k++) tick();
    chk_eq("t1_ack", ack[0], 1);
    chk_eq("t1_gid", grant_id, 0);
    req = '0;
    for (int k = 0; k < 20 && busy; k++) tick();
    chk_eq("t1_done", busy, 0);
    chk_eq("t1_err", timeout_err, 0);

    // requesters 0,1,3 drop on ack and re-raise one cycle later
    do_reset();
    grants.delete();
    gap_lo = 1; gap_hi = 1; hold_hi = 0;
    start_clients(4'b1011);
    for (int k = 0; k < 400 && grants.size() < 6; k++) tick();
    drain_clients("t2_drain");
    chk_eq("t2_count", (grants.size() >= 6) ? 1 : 0, 1);
    for (int k = 0; k < 6; k++) begin
      int exp_g;
      exp_g = (k % 3 == 2) ? 3 : k % 3;
      chk_eq("t2_order", (k < grants.size()) ? grants[k] : -1, exp_g);
    end

    // all four requesters continuously re-raising, 40 grants
    do_reset();
    grants.delete();
    start_clients(4'b1111);
    for (int k = 0; k < 1000 && grants.size() < 40; k++) tick();
    drain_clients("t3_drain");
    chk_eq("t3_count", (grants.size() >= 40) ? 1 : 0, 1);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int k = 0; k < 40 && k < grants.size(); k++) begin
      chk_eq("t3_order", grants[k], k % 4);
      cnt[grants[k] % N]++;
    end
    for (int i = 0; i < N; i++) chk_eq("t3_fair", cnt[i], 10);

    // randomized traffic in segments with random masks, gaps and holds
    grants.delete();
    gap_lo = 1; gap_hi = 8; hold_hi = 3;
    for (int s = 0; s < 4; s++) begin
      start_clients(4'($urandom_range(15, 1)));
      repeat (200) tick();
      drain_clients("t4_drain");
    end
    chk_eq("t4_any_grants", (grants.size() > 0) ? 1 : 0, 1);

    // chain output stuck low: FIRE times out
    stuck0 = 1'b1;
    fire_lat = TMO;
    drain_lat = 1;
    req = 4'b0001;
    for (int k = 0; k < 40 && !ack[0]; k++) tick();
    chk_eq("t5_ack", ack[0], 1);
    chk_eq("t5_err_set", timeout_err, 1);
    req = '0;
    for (int k = 0; k < 20 && busy; k++) tick();
    chk_eq("t5_done", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    chk_eq("t5_err_clr", timeout_err, 0);
    req = 4'b0001;
    for (int k = 0; k < 10 && ph != PH_FIRE; k++) tick();
    for (int k = 0; k < 40 && (cyc - t0) < TMO - 1; k++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_eq("t5_coincide_ack", ack[0], 1);
    chk_eq("t5_coincide_err", timeout_err, 1);
    req = '0;
    for (int k = 0; k < 20 && busy; k++) tick();
    chk_eq("t5_done2", busy, 0);
    stuck0 = 1'b0;
    fire_lat = 3;
    drain_lat = 3;
    tick();

    // req[2] dropped during FIRE
    req = 4'b0100;
    for (int k = 0; k < 10 && ph != PH_FIRE; k++) tick();
    req = '0;
    for (int k = 0; k < 30 && busy; k++) tick();
    chk_eq("t6_gid", grant_id, 2);
    chk_eq("t6_done", busy, 0);

    // reset two cycles into FIRE
    req = 4'b0110;
    for (int k = 0; k < 10 && ph != PH_FIRE; k++) tick();
    chk_eq("t7_pre_gid", grant_id, 1);
    tick();
    tick();
    rstn = 1'b0;
    model_reset();
    #1;
    chk_eq("t7_del_in", del_in, 0);
    chk_eq("t7_ack", ack, 0);
    chk_eq("t7_busy", busy, 0);
    chk_eq("t7_err", timeout_err, 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk_eq("t7_post_gid", grant_id, 1);
    for (int k = 0; k < 20 && !ack[1]; k++) tick();
    chk_eq("t7_ack1", ack[1], 1);
    req = '0;
    for (int k = 0; k < 20 && busy; k++) tick();
    chk_eq("t7_done", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
